picomips_ctrl_fsm: RTL and testbench
====================================

// Module: picomips_ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle control unit for the picoMIPS core. Decodes the 6-bit opcode and drives
//  PC control, the imm MUX, register-file write enables and ALUfunc, as in the single-cycle decoder.
//  Adds sequencing for multi-cycle MUL, two-cycle conditional branches, HALT, a pipeline stall input
//  and illegal-opcode detection. Sits between program memory and the datapath (PC, regs, ALU).
// PARAMETERS
//  OPW          6  opcode width
//  FW           4  ALUfunc width
//  MUL_CYCLES   4  total cycles for MUL/MULI (>=1; 1 = single cycle, S_MUL never entered)
//  TRAP_ILLEGAL 0  1: illegal opcode enters S_HALT; 0: illegal opcode executes as NOP
// PORTS
//  clk      in   1    clock, all state updates on rising edge
//  reset    in   1    synchronous, active-high
//  stall    in   1    1 = hold: state/counter frozen, all write/PC strobes forced 0
//  opcode   in   OPW  top bits of current instruction
//  zero     in   1    ALU zero flag, combinational from current ALU result
//  PCincr   out  1    PC <= PC+1
//  PCload   out  1    PC <= PC+imm (branch taken); never together with PCincr
//  ALUfunc  out  FW   ALU operation select
//  imm      out  1    route immediate field to ALU operand b
//  w1       out  1    write ALU result to destination register
//  w2       out  1    write zero flag into flag register
//  busy     out  1    1 while a multi-cycle instruction is in progress
//  halted   out  1    1 in S_HALT
//  illegal  out  1    one-cycle pulse on an undefined opcode
// BEHAVIOUR
//  States: S_RUN (fetch/decode/execute one instruction), S_MUL, S_BR, S_HALT. Reset -> S_RUN.
//  Outputs are combinational from (state, opcode, zero, count). While reset=1 all outputs are 0.
//  Default each cycle: PCincr=1, all other outputs 0, ALUfunc=ALU_PASS.
//  S_RUN decode:
//   NOP: defaults.  ADD: ALU_ADD, w1.  ADDI: ALU_ADD, imm, w1.  SUB: ALU_SUB, w1, w2.
//   SUBI: ALU_SUB, imm, w1, w2.
//   MUL/MULI: ALU_MUL (+imm for MULI). If MUL_CYCLES==1: w1, PCincr=1. Else: PCincr=0, w1=0,
//    busy=1, count<=MUL_CYCLES-2, goto S_MUL.
//   BEQ/BNE: ALU_SUB, PCincr=0, busy=1, cond<=(BEQ ? zero : !zero), goto S_BR.
//   HALT: PCincr=0, goto S_HALT.
//   Other: illegal=1. TRAP_ILLEGAL=0 -> NOP. TRAP_ILLEGAL=1 -> PCincr=0, goto S_HALT.
//  S_MUL: ALUfunc=ALU_MUL, imm held from opcode, busy=1.
//   count!=0: PCincr=0, count<=count-1.  count==0: w1=1, PCincr=1, goto S_RUN.
//   MUL latency is exactly MUL_CYCLES cycles, opcode input held stable by the PC.
//  S_BR: imm=1, busy=1. cond=1: PCload=1, PCincr=0. cond=0: PCincr=1. Then goto S_RUN.
//  S_HALT: PCincr=0, halted=1, all strobes 0. Exit only by reset.
//  stall=1, any state: PCincr=PCload=w1=w2=illegal=0. State, count and cond hold. busy/halted/ALUfunc/imm
//   still reflect the current state.
//  Reset mid-MUL or mid-branch: next cycle S_RUN, count=0, cond=0. No pending write or PC load.
//  count width = $clog2(MUL_CYCLES) (min 1). No wrap: the decrement only happens while count!=0.
// STRUCTURE
//  picomips_pkg: opcode localparams (NOP=6'h00, ADD=6'h01, ADDI=6'h02, SUB=6'h03, SUBI=6'h04,
//   MUL=6'h05, MULI=6'h06, BEQ=6'h08, BNE=6'h09, HALT=6'h3F), ALU func enum (ALU_PASS=0, ALU_ADD=2,
//   ALU_SUB=3, ALU_MUL=4), state enum. Replaces opcodes.sv for new code.
//  One always_ff for state/count/cond and one always_comb for outputs/next state.
//  No sub-module; the cycle counter stays inline.
// TESTING
//  1 reset=1 for 2 cycles, opcode=ADDI -> all outputs 0. Release -> ALUfunc=2, imm=1, w1=1, PCincr=1.
//  2 MUL, MUL_CYCLES=4 -> cycles 1-3: PCincr=0, busy=1, w1=0. Cycle 4: w1=1, PCincr=1, then S_RUN.
//    Repeat with MUL_CYCLES=1 -> single cycle with w1=1, PCincr=1.
//  3 BEQ with zero=1 -> cycle 1: ALU_SUB, PCincr=0. Cycle 2: PCload=1, imm=1.
//    BEQ with zero=0 -> cycle 2: PCincr=1, PCload=0. BNE gives the inverse results.
//  4 stall=1 for 3 cycles in the middle of a MUL -> strobes 0 and count frozen.
//    After release the remaining cycles complete; w1 is asserted exactly once.
//  5 reset during S_MUL (count=1) -> next cycle S_RUN, busy=0, no w1 pulse.
//  6 opcode=6'h2A -> illegal pulses for 1 cycle, NOP behaviour (TRAP_ILLEGAL=0).
//    TRAP_ILLEGAL=1 -> halted=1, PCincr=0 until reset. HALT opcode -> same halted behaviour.

Source files
------------

// File: rtl/picomips_pkg.sv
// picoMIPS shared definitions.
//
// Purpose: opcode encodings, ALU function codes and the control FSM state
// encoding used by the picoMIPS control unit and datapath. New code imports
// this package instead of the old opcodes.sv include.
//
// Contents:
//   NOP..HALT       6-bit opcode encodings (top bits of the instruction word)
//   alu_func_t      ALU operation select values
//   state_t         control FSM states
//   count_width()   width of the multi-cycle MUL counter for a given latency
package picomips_pkg;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] ADDI = 6'h02;
  localparam logic [5:0] SUB  = 6'h03;
  localparam logic [5:0] SUBI = 6'h04;
  localparam logic [5:0] MUL  = 6'h05;
  localparam logic [5:0] MULI = 6'h06;
  localparam logic [5:0] BEQ  = 6'h08;
  localparam logic [5:0] BNE  = 6'h09;
  localparam logic [5:0] HALT = 6'h3F;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_MUL  = 4'd4
  } alu_func_t;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,  // fetch/decode/execute one instruction
    S_MUL  = 2'd1,  // remaining cycles of a multi-cycle multiply
    S_BR   = 2'd2,  // second cycle of a conditional branch
    S_HALT = 2'd3   // stopped until reset
  } state_t;

  // The counter holds at most MUL_CYCLES-2, so $clog2(MUL_CYCLES) bits are
  // enough; keep at least one bit so the register always exists.
  function automatic int unsigned count_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/picomips_ctrl_fsm.sv
// picoMIPS multi-cycle control unit.
//
// Purpose: decodes the current opcode and drives PC control, the immediate
// MUX, register-file write enables and ALUfunc. Adds sequencing for
// multi-cycle MUL/MULI, two-cycle conditional branches, HALT, a stall input
// and illegal-opcode detection.
//
// Parameters:
//   OPW          opcode width
//   FW           ALUfunc width
//   MUL_CYCLES   total cycles of MUL/MULI (1 = single cycle)
//   TRAP_ILLEGAL 1: illegal opcode halts the core, 0: executes as NOP
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; forces every output to 0
//   stall    in   hold state/count/cond, force PC and write strobes to 0
//   opcode   in   top bits of the current instruction
//   zero     in   ALU zero flag of the current ALU result
//   PCincr   out  PC <= PC+1
//   PCload   out  PC <= PC+imm (branch taken), never with PCincr
//   ALUfunc  out  ALU operation select
//   imm      out  route immediate field to ALU operand b
//   w1       out  write ALU result to destination register
//   w2       out  write zero flag into flag register
//   busy     out  multi-cycle instruction in progress
//   halted   out  core in S_HALT
//   illegal  out  one-cycle pulse on an undefined opcode
//
// Handshake: there is no valid/ready pair here. The PC holds the opcode
// stable whenever PCincr and PCload are both 0, which is what lets S_MUL and
// S_BR keep decoding fields of the same instruction.
module picomips_ctrl_fsm
  import picomips_pkg::*;
#(
  parameter int unsigned OPW          = 6,
  parameter int unsigned FW           = 4,
  parameter int unsigned MUL_CYCLES   = 4,
  parameter bit          TRAP_ILLEGAL = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           PCincr,
  output logic           PCload,
  output logic [FW-1:0]  ALUfunc,
  output logic           imm,
  output logic           w1,
  output logic           w2,
  output logic           busy,
  output logic           halted,
  output logic           illegal
);

  localparam int unsigned CW = count_width(MUL_CYCLES);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          cond_q, cond_d;
  alu_func_t     alu_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      count_q <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cond_d  = cond_q;
    alu_sel = ALU_PASS;
    PCincr  = 1'b1;
    PCload  = 1'b0;
    imm     = 1'b0;
    w1      = 1'b0;
    w2      = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      S_RUN: begin
        case (opcode)
          OPW'(NOP): ;
          OPW'(ADD): begin
            alu_sel = ALU_ADD;
            w1      = 1'b1;
          end
          OPW'(ADDI): begin
            alu_sel = ALU_ADD;
            imm     = 1'b1;
            w1      = 1'b1;
          end
          OPW'(SUB): begin
            alu_sel = ALU_SUB;
            w1      = 1'b1;
            w2      = 1'b1;
          end
          OPW'(SUBI): begin
            alu_sel = ALU_SUB;
            imm     = 1'b1;
            w1      = 1'b1;
            w2      = 1'b1;
          end
          OPW'(MUL), OPW'(MULI): begin
            alu_sel = ALU_MUL;
            imm     = (opcode == OPW'(MULI));
            if (MUL_CYCLES == 1) begin
              w1 = 1'b1;
            end else begin
              // This decode cycle is the first of MUL_CYCLES; S_MUL counts
              // the rest down and writes on the cycle where count reaches 0.
              PCincr  = 1'b0;
              busy    = 1'b1;
              count_d = CW'(MUL_CYCLES - 2);
              state_d = S_MUL;
            end
          end
          OPW'(BEQ), OPW'(BNE): begin
            // Compare now, latch the branch decision; the flag may change
            // before the second cycle when the ALU switches to PASS.
            alu_sel = ALU_SUB;
            PCincr  = 1'b0;
            busy    = 1'b1;
            cond_d  = (opcode == OPW'(BEQ)) ? zero : !zero;
            state_d = S_BR;
          end
          OPW'(HALT): begin
            PCincr  = 1'b0;
            state_d = S_HALT;
          end
          default: begin
            illegal = 1'b1;
            if (TRAP_ILLEGAL) begin
              PCincr  = 1'b0;
              state_d = S_HALT;
            end
          end
        endcase
      end

      S_MUL: begin
        alu_sel = ALU_MUL;
        imm     = (opcode == OPW'(MULI));
        busy    = 1'b1;
        if (count_q != '0) begin
          PCincr  = 1'b0;
          count_d = count_q - CW'(1);
        end else begin
          w1      = 1'b1;
          state_d = S_RUN;
        end
      end

      S_BR: begin
        imm     = 1'b1;
        busy    = 1'b1;
        PCload  = cond_q;
        PCincr  = !cond_q;
        state_d = S_RUN;
      end

      S_HALT: begin
        PCincr = 1'b0;
        halted = 1'b1;
      end

      default: state_d = S_RUN;
    endcase

    // Stall freezes sequencing and suppresses every side effect, but the
    // state-derived indications stay visible.
    if (stall) begin
      state_d = state_q;
      count_d = count_q;
      cond_d  = cond_q;
      PCincr  = 1'b0;
      PCload  = 1'b0;
      w1      = 1'b0;
      w2      = 1'b0;
      illegal = 1'b0;
    end

    if (reset) begin
      alu_sel = ALU_PASS;
      PCincr  = 1'b0;
      PCload  = 1'b0;
      imm     = 1'b0;
      w1      = 1'b0;
      w2      = 1'b0;
      busy    = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;
    end

    ALUfunc = FW'(alu_sel);
  end

endmodule

// File: tb/tb_picomips_ctrl_fsm.sv
// Bench for picomips_ctrl_fsm. Two instances share the inputs:
//   dut_a: MUL_CYCLES=4, TRAP_ILLEGAL=0
//   dut_b: MUL_CYCLES=1, TRAP_ILLEGAL=1
// Outputs are packed as {PCincr,PCload,ALUfunc[3:0],imm,w1,w2,busy,halted,illegal}.
module tb_picomips_ctrl_fsm;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] ADDI = 6'h02;
  localparam logic [5:0] SUB  = 6'h03;
  localparam logic [5:0] SUBI = 6'h04;
  localparam logic [5:0] MUL  = 6'h05;
  localparam logic [5:0] MULI = 6'h06;
  localparam logic [5:0] BEQ  = 6'h08;
  localparam logic [5:0] BNE  = 6'h09;
  localparam logic [5:0] HALT = 6'h3F;
  localparam logic [5:0] BAD  = 6'h2A;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset, stall, zero;
  logic [5:0] opcode;

  always #5 clk = ~clk;

  logic       pci_a, pcl_a, imm_a, w1_a, w2_a, busy_a, hlt_a, ill_a;
  logic [3:0] alu_a;
  logic       pci_b, pcl_b, imm_b, w1_b, w2_b, busy_b, hlt_b, ill_b;
  logic [3:0] alu_b;
  logic [11:0] oa, ob;

  assign oa = {pci_a, pcl_a, alu_a, imm_a, w1_a, w2_a, busy_a, hlt_a, ill_a};
  assign ob = {pci_b, pcl_b, alu_b, imm_b, w1_b, w2_b, busy_b, hlt_b, ill_b};

  picomips_ctrl_fsm #(.OPW(6), .FW(4), .MUL_CYCLES(4), .TRAP_ILLEGAL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .zero(zero),
    .PCincr(pci_a), .PCload(pcl_a), .ALUfunc(alu_a), .imm(imm_a), .w1(w1_a),
    .w2(w2_a), .busy(busy_a), .halted(hlt_a), .illegal(ill_a)
  );

  picomips_ctrl_fsm #(.OPW(6), .FW(4), .MUL_CYCLES(1), .TRAP_ILLEGAL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .zero(zero),
    .PCincr(pci_b), .PCload(pcl_b), .ALUfunc(alu_b), .imm(imm_b), .w1(w1_b),
    .w2(w2_b), .busy(busy_b), .halted(hlt_b), .illegal(ill_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] v(input logic pi, input logic pl, input logic [3:0] f,
                                    input logic im, input logic a, input logic b,
                                    input logic bs, input logic h, input logic il);
    return {pi, pl, f, im, a, b, bs, h, il};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled 2
  // units later, well before the next edge.
  task automatic set_in(input logic r, input logic s, input logic [5:0] op, input logic z);
    reset  = r;
    stall  = s;
    opcode = op;
    zero   = z;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  int w1_count;

  initial begin
    // ---- 1: reset, then basic decode ----
    set_in(1, 0, ADDI, 0);
    check("rst_c1_a", oa, 12'h000);
    check("rst_c1_b", ob, 12'h000);
    tick();
    set_in(1, 0, ADDI, 1);
    check("rst_c2_a", oa, 12'h000);
    tick();
    set_in(0, 0, ADDI, 0);
    check("addi_a", oa, v(1, 0, 4'd2, 1, 1, 0, 0, 0, 0));
    check("addi_b", ob, v(1, 0, 4'd2, 1, 1, 0, 0, 0, 0));
    tick();
    set_in(0, 0, ADD, 0);
    check("add_a", oa, v(1, 0, 4'd2, 0, 1, 0, 0, 0, 0));
    tick();
    set_in(0, 0, SUB, 1);
    check("sub_a", oa, v(1, 0, 4'd3, 0, 1, 1, 0, 0, 0));
    tick();
    set_in(0, 0, SUBI, 0);
    check("subi_a", oa, v(1, 0, 4'd3, 1, 1, 1, 0, 0, 0));
    tick();
    set_in(0, 0, NOP, 1);
    check("nop_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    tick();

    // ---- 2: MUL, 4 cycles on dut_a, 1 cycle on dut_b ----
    for (int c = 1; c <= 3; c++) begin
      set_in(0, 0, MUL, rnd_bit());
      check($sformatf("mul_c%0d_a", c), oa, v(0, 0, 4'd4, 0, 0, 0, 1, 0, 0));
      check($sformatf("mul_c%0d_b", c), ob, v(1, 0, 4'd4, 0, 1, 0, 0, 0, 0));
      tick();
    end
    set_in(0, 0, MUL, 0);
    check("mul_c4_a", oa, v(1, 0, 4'd4, 0, 1, 0, 1, 0, 0));
    tick();
    set_in(0, 0, NOP, 0);
    check("mul_done_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    tick();

    // ---- 3: branches; zero flips in cycle 2 to prove cond is latched ----
    set_in(0, 0, BEQ, 1);
    check("beq_z1_c1_a", oa, v(0, 0, 4'd3, 0, 0, 0, 1, 0, 0));
    check("beq_z1_c1_b", ob, v(0, 0, 4'd3, 0, 0, 0, 1, 0, 0));
    tick();
    set_in(0, 0, BEQ, 0);
    check("beq_z1_c2_a", oa, v(0, 1, 4'd0, 1, 0, 0, 1, 0, 0));
    tick();
    set_in(0, 0, NOP, 0);
    check("beq_after_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    tick();
    set_in(0, 0, BEQ, 0);
    tick();
    set_in(0, 0, BEQ, 1);
    check("beq_z0_c2_a", oa, v(1, 0, 4'd0, 1, 0, 0, 1, 0, 0));
    tick();
    set_in(0, 0, BNE, 1);
    check("bne_z1_c1_a", oa, v(0, 0, 4'd3, 0, 0, 0, 1, 0, 0));
    tick();
    set_in(0, 0, BNE, 0);
    check("bne_z1_c2_a", oa, v(1, 0, 4'd0, 1, 0, 0, 1, 0, 0));
    tick();
    set_in(0, 0, BNE, 0);
    tick();
    set_in(0, 0, BNE, 1);
    check("bne_z0_c2_a", oa, v(0, 1, 4'd0, 1, 0, 0, 1, 0, 0));
    check("bne_z0_c2_b", ob, v(0, 1, 4'd0, 1, 0, 0, 1, 0, 0));
    tick();

    // ---- 4: stall 3 cycles in the middle of MULI ----
    w1_count = 0;
    set_in(0, 0, MULI, 0);
    check("muli_c1_a", oa, v(0, 0, 4'd4, 1, 0, 0, 1, 0, 0));
    w1_count += int'(w1_a);
    tick();
    set_in(0, 0, MULI, 0);
    w1_count += int'(w1_a);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1, MULI, rnd_bit());
      check($sformatf("muli_stall%0d_a", c), oa, v(0, 0, 4'd4, 1, 0, 0, 1, 0, 0));
      check($sformatf("muli_stall%0d_b", c), ob, v(0, 0, 4'd4, 1, 0, 0, 0, 0, 0));
      w1_count += int'(w1_a);
      tick();
    end
    set_in(0, 0, MULI, 0);
    check("muli_resume_a", oa, v(0, 0, 4'd4, 1, 0, 0, 1, 0, 0));
    w1_count += int'(w1_a);
    tick();
    set_in(0, 0, MULI, 0);
    check("muli_last_a", oa, v(1, 0, 4'd4, 1, 1, 0, 1, 0, 0));
    w1_count += int'(w1_a);
    tick();
    set_in(0, 0, NOP, 0);
    check("muli_done_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    check("muli_w1_once", 12'(w1_count), 12'd1);
    tick();

    // ---- 5: reset while count=1 ----
    set_in(0, 0, MUL, 0);
    tick();
    set_in(0, 0, MUL, 0);
    tick();
    set_in(1, 0, MUL, 0);
    check("mul_rst_a", oa, 12'h000);
    tick();
    set_in(0, 0, NOP, 0);
    check("mul_after_rst_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    tick();

    // ---- 6: illegal opcode, trap and HALT ----
    set_in(0, 0, BAD, 0);
    check("ill_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 1));
    check("ill_b", ob, v(0, 0, 4'd0, 0, 0, 0, 0, 0, 1));
    tick();
    set_in(0, 0, NOP, 0);
    check("ill_next_a", oa, v(1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    check("trap_b", ob, v(0, 0, 4'd0, 0, 0, 0, 0, 1, 0));
    tick();
    set_in(0, 0, ADD, rnd_bit());
    check("trap_hold_b", ob, v(0, 0, 4'd0, 0, 0, 0, 0, 1, 0));
    check("add_a2", oa, v(1, 0, 4'd2, 0, 1, 0, 0, 0, 0));
    tick();
    set_in(1, 0, ADD, 0);
    tick();
    set_in(0, 0, ADD, 0);
    check("trap_rst_b", ob, v(1, 0, 4'd2, 0, 1, 0, 0, 0, 0));
    tick();
    set_in(0, 0, HALT, 0);
    check("halt_c1_a", oa, v(0, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    tick();
    set_in(0, 0, ADD, 1);
    check("halted_a", oa, v(0, 0, 4'd0, 0, 0, 0, 0, 1, 0));
    tick();
    set_in(0, 1, SUB, 0);
    check("halted_stall_a", oa, v(0, 0, 4'd0, 0, 0, 0, 0, 1, 0));
    tick();
    set_in(1, 0, ADD, 0);
    tick();
    set_in(0, 0, ADD, 0);
    check("halt_rst_a", oa, v(1, 0, 4'd2, 0, 1, 0, 0, 0, 0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
